// File: rtl/rdn_pkg.sv
// rtl/rdn_pkg.sv - shared constants and types for the RDN weight-load path
//
// Purpose : network dimensions, derived weight-word/line totals and the
//           weight-stream FSM state type.
// Ports   : none (package).
package rdn_pkg;

  localparam int NUM_A_NEURONS  = 15;
  localparam int NUM_B_NEURONS  = 15;
  localparam int NUM_C_NEURONS  = 36;
  localparam int A_INPUTS       = 400;
  localparam int WORDS_PER_LINE = 4;

  // Every neuron carries one bias word on top of its input weights.
  localparam int NUM_WEIGHT_WORDS = NUM_A_NEURONS * (A_INPUTS + 1)
                                  + NUM_B_NEURONS * (NUM_A_NEURONS + 1)
                                  + NUM_C_NEURONS * (NUM_B_NEURONS + 1);
  localparam int NUM_WEIGHT_LINES = (NUM_WEIGHT_WORDS + WORDS_PER_LINE - 1) / WORDS_PER_LINE;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } rdn_wstream_state_t;

endpackage

// File: rtl/rdn_line_fifo.sv
// rtl/rdn_line_fifo.sv - show-ahead line buffer for the weight stream
//
// Purpose : synchronous FIFO holding fetched weight lines; head is visible
//           combinationally so the serializer can slice it directly.
// Ports   : clk, rst (async, active-high)
//           clr              - synchronous flush
//           push, push_data  - write one line
//           pop              - drop the head line
//           head             - oldest line
//           count            - lines currently held
module rdn_line_fifo #(
  parameter  int W     = 64,
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);

  localparam logic [AW-1:0] PTR_MAX_C = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_C    = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == PTR_MAX_C) ? '0 : p + 1'b1;
  endfunction

  assign do_push = push && (cnt_q != FULL_C);
  assign do_pop  = pop && (cnt_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: nothing is read while count is zero.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = cnt_q;

endmodule

// File: rtl/rdn_weight_stream.sv
// rtl/rdn_weight_stream.sv - weight-line fetcher and 16-bit word serializer
//
// Purpose : fetches NUM_WORDS packed weight words from memory as LINE_W-bit
//           lines and streams them little-endian to the weight loader.
// Ports   : clk, rst (async, active-high)
//           start, base_addr                  - begin a load at base_addr
//           mem_req, mem_addr, mem_gnt         - read request channel
//           mem_rvalid, mem_rdata              - in-order read responses
//           wt_valid, wt_data, wt_ready        - weight word stream
//           busy, done                         - load status
//           cksum (RDN_WSTREAM_CKSUM_EN only)  - 16-bit sum of accepted words
// Option  : define RDN_WSTREAM_CKSUM_EN to add the cksum output.
module rdn_weight_stream
  import rdn_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int LINE_W     = 64,
  parameter int FIFO_LINES = 4,
  parameter int NUM_WORDS  = NUM_WEIGHT_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              wt_valid,
  output logic [15:0]       wt_data,
  input  logic              wt_ready,
  output logic              busy,
  output logic              done
`ifdef RDN_WSTREAM_CKSUM_EN
  ,
  output logic [15:0]       cksum
`endif
);

  localparam int WPL       = LINE_W / 16;
  localparam int IDX_W     = $clog2(WPL);
  localparam int BYTE_SH   = $clog2(LINE_W / 8);
  localparam int NUM_LINES = (NUM_WORDS + WPL - 1) / WPL;
  localparam int LCNT_W    = $clog2(NUM_LINES + 1);
  localparam int WCNT_W    = $clog2(NUM_WORDS + 1);
  localparam int CNT_W     = $clog2(FIFO_LINES + 1);

  localparam logic [LCNT_W-1:0] LINES_C     = LCNT_W'(NUM_LINES);
  localparam logic [LCNT_W-1:0] LAST_LINE_C = LCNT_W'(NUM_LINES - 1);
  localparam logic [WCNT_W-1:0] WORDS_C     = WCNT_W'(NUM_WORDS);
  localparam logic [WCNT_W-1:0] LAST_WORD_C = WCNT_W'(NUM_WORDS - 1);
  localparam logic [IDX_W-1:0]  IDX_MAX_C   = IDX_W'(WPL - 1);
  localparam logic [CNT_W:0]    CREDITS_C   = (CNT_W + 1)'(FIFO_LINES);

  rdn_wstream_state_t state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [LCNT_W-1:0]  lines_q, lines_d;
  logic [CNT_W-1:0]   outst_q, outst_d;
  logic [WCNT_W-1:0]  words_q, words_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               rv_q;
  logic [LINE_W-1:0]  rdata_q;

  logic [LINE_W-1:0]  fifo_head;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_clr, fifo_pop;
  logic [CNT_W:0]     inflight;
  logic               grant, accept, last_word, line_end;
  logic [15:0]        head_word;

  // Responses are registered once before entering the buffer; the line stays
  // counted as outstanding until it is actually pushed, so credits never lapse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rv_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      rv_q <= mem_rvalid && (state_q != ST_IDLE);
      if (mem_rvalid) rdata_q <= mem_rdata;
    end
  end

  rdn_line_fifo #(
    .W     (LINE_W),
    .DEPTH (FIFO_LINES)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (fifo_clr),
    .push      (rv_q),
    .push_data (rdata_q),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  // Requested-but-unbuffered lines plus buffered lines may not exceed the
  // buffer depth; this sum only grows on a grant, which keeps a pending
  // request stable until it is granted.
  assign inflight = {1'b0, outst_q} + {1'b0, fifo_count};
  assign mem_req  = (state_q == ST_RUN) && (inflight < CREDITS_C) && (lines_q < LINES_C);
  assign mem_addr = base_q + (ADDR_W'(lines_q) << BYTE_SH);
  assign grant    = mem_req && mem_gnt;

  assign head_word = fifo_head[{idx_q, 4'b0000} +: 16];
  assign wt_valid  = (fifo_count != '0);
  assign wt_data   = wt_valid ? head_word : 16'h0000;
  assign accept    = wt_valid && wt_ready;
  // The last line of the load may be partial: it pops after the final word.
  assign last_word = (words_q == LAST_WORD_C);
  assign line_end  = (idx_q == IDX_MAX_C) || last_word;
  assign fifo_pop  = accept && line_end;

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    lines_d  = lines_q;
    outst_d  = outst_q;
    words_d  = words_q;
    idx_d    = idx_q;
    fifo_clr = 1'b0;

    case ({grant, rv_q})
      2'b10:   outst_d = outst_q + 1'b1;
      2'b01:   outst_d = outst_q - 1'b1;
      default: outst_d = outst_q;
    endcase
    if (grant) lines_d = lines_q + 1'b1;
    if (accept) begin
      words_d = (words_q == WORDS_C) ? words_q : words_q + 1'b1;
      idx_d   = line_end ? '0 : idx_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d   = base_addr;
          lines_d  = '0;
          outst_d  = '0;
          words_d  = '0;
          idx_d    = '0;
          fifo_clr = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (grant && (lines_q == LAST_LINE_C)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (accept && last_word) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      lines_q <= '0;
      outst_q <= '0;
      words_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      lines_q <= lines_d;
      outst_q <= outst_d;
      words_q <= words_d;
      idx_q   <= idx_d;
    end
  end

`ifdef RDN_WSTREAM_CKSUM_EN
  logic [15:0] cksum_q, cksum_d;

  always_comb begin
    cksum_d = cksum_q;
    if ((state_q == ST_IDLE) && start) cksum_d = 16'h0000;
    else if (accept)                   cksum_d = cksum_q + wt_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cksum_q <= 16'h0000;
    else     cksum_q <= cksum_d;
  end

  assign cksum = cksum_q;
`endif

endmodule

// File: tb/tb_rdn_weight_stream.sv
// tb/tb_rdn_weight_stream.sv - self-checking bench for rdn_weight_stream
//
// Purpose : drives randomized memory latency/grant and loader back-pressure,
//           checks grants, addresses, word order, stalls and status against a
//           line-indexed reference model.
// Ports   : none (top-level bench). Define RDN_WSTREAM_CKSUM_EN to also
//           exercise the cksum output.
module tb_rdn_weight_stream;

  localparam int NW         = 6831;
  localparam int NL         = 1708;
  localparam int FIFO_LINES = 4;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] base_addr;
  logic        mem_req, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr;
  logic [63:0] mem_rdata;
  logic        wt_valid, wt_ready, busy, done;
  logic [15:0] wt_data;
`ifdef RDN_WSTREAM_CKSUM_EN
  logic [15:0] cksum;
`endif

  rdn_weight_stream dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .wt_valid   (wt_valid),
    .wt_data    (wt_data),
    .wt_ready   (wt_ready),
    .busy       (busy),
    .done       (done)
`ifdef RDN_WSTREAM_CKSUM_EN
    ,
    .cksum      (cksum)
`endif
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_bad = 0;
  int          lat, gnt_pct, rdy_pct;
  bit          ones_mode, junk_en;
  logic [31:0] m_base, last_gaddr, stall_addr;
  logic [15:0] stall_data, m_sum;
  int          n_grant, exp_idx, n_done, cyc, first_rv;
  bit          first_wv_done, req_stall, w_stall, prev_done;
  logic [63:0] q_data[$];
  int          q_due[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Content of weight line 'line' of the current load.
  function automatic logic [63:0] line_data(input int line);
    logic [31:0] a;
    if (ones_mode) return {4{16'h0001}};
    if (line == NL - 1) return 64'hDDDD_CCCC_BBBB_AAAA;
    a = m_base + 32'(line) * 32'd8;
    return {a[31:16] ^ 16'h5A5A, a[15:0] + 16'd6, ~a[15:0], a[15:0]};
  endfunction

  function automatic logic [15:0] exp_word(input int n);
    logic [63:0] d;
    d = line_data(n / 4);
    return d[(n % 4) * 16 +: 16];
  endfunction

  // One clock: sample DUT at the falling edge, model memory and loader, and
  // drive the inputs for the next rising edge.
  task automatic tick();
    bit g, r;
    @(negedge clk);
    cyc++;
    if (rst) begin
      q_data.delete();
      q_due.delete();
      req_stall  = 0;
      w_stall    = 0;
      prev_done  = 0;
      mem_gnt    = 0;
      mem_rvalid = 0;
      mem_rdata  = '0;
      wt_ready   = 0;
      return;
    end

    if (prev_done) check("busy_after_done", busy, 0);
    if (done) begin
      n_done++;
      check("done_word_count", exp_idx, NW);
      check("done_grant_count", n_grant, NL);
    end
    prev_done = done;

    if (req_stall) begin
      check("req_hold", mem_req, 1);
      check("addr_hold", mem_addr, stall_addr);
    end
    g = ($urandom_range(99) < gnt_pct);
    mem_gnt = g;
    req_stall = 0;
    if (mem_req) begin
      if (g) begin
        check("grant_in_range", n_grant < NL, 1);
        check("addr", mem_addr, m_base + 32'(n_grant) * 32'd8);
        q_data.push_back(line_data(int'((mem_addr - m_base) >> 3)));
        q_due.push_back(cyc + lat);
        n_grant++;
        last_gaddr = mem_addr;
        check("outstanding", q_data.size() <= FIFO_LINES, 1);
      end else begin
        req_stall  = 1;
        stall_addr = mem_addr;
      end
    end

    if (junk_en) begin
      mem_rvalid = 1'($urandom_range(1));
      mem_rdata  = {$urandom, $urandom};
    end else if (q_due.size() > 0 && q_due[0] <= cyc) begin
      mem_rvalid = 1;
      mem_rdata  = q_data.pop_front();
      void'(q_due.pop_front());
      if (first_rv < 0) first_rv = cyc;
    end else begin
      mem_rvalid = 0;
      mem_rdata  = {$urandom, $urandom};
    end

    if (w_stall) begin
      check("wt_valid_hold", wt_valid, 1);
      check("wt_data_hold", wt_data, stall_data);
    end
    r = ($urandom_range(99) < rdy_pct);
    wt_ready = r;
    w_stall = 0;
    if (wt_valid) begin
      if (!first_wv_done) begin
        check("first_word_latency", (first_rv >= 0) && (cyc - first_rv >= 2), 1);
        first_wv_done = 1;
      end
      if (r) begin
        check("extra_word", exp_idx < NW, 1);
        check("wt_data", wt_data, exp_word(exp_idx));
        m_sum = m_sum + wt_data;
        exp_idx++;
      end else begin
        w_stall    = 1;
        stall_data = wt_data;
      end
    end
  endtask

  task automatic start_load(input logic [31:0] base);
    m_base        = base;
    n_grant       = 0;
    exp_idx       = 0;
    m_sum         = 0;
    first_rv      = -1;
    first_wv_done = 0;
    base_addr     = base;
    start         = 1;
    tick();
    start     = 0;
    base_addr = $urandom;
  endtask

  task automatic run_load(input logic [31:0] base, input int max_cyc);
    int d0;
    d0 = n_done;
    start_load(base);
    for (int i = 0; i < max_cyc && n_done == d0; i++) tick();
    check("load_completed", n_done, d0 + 1);
    tick();
    tick();
    check("single_done", n_done, d0 + 1);
    check("busy_idle", busy, 0);
    check("grants_total", n_grant, NL);
    check("words_total", exp_idx, NW);
`ifdef RDN_WSTREAM_CKSUM_EN
    check("cksum", cksum, m_sum);
`endif
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_mem_req"}, mem_req, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_wt_valid"}, wt_valid, 0);
    check({tag, "_wt_data"}, wt_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  initial begin
    int d0;
    rst = 1; start = 0; base_addr = '0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0; wt_ready = 0;
    lat = 1; gnt_pct = 100; rdy_pct = 100; ones_mode = 0; junk_en = 0;
    n_done = 0; cyc = 0; first_rv = -1; last_gaddr = '0; m_base = '0;
    #1;
    check_quiet("reset");
`ifdef RDN_WSTREAM_CKSUM_EN
    check("reset_cksum", cksum, 0);
`endif
    tick(); tick();
    rst = 0;
    tick();
    check_quiet("idle");

    // Zero-latency memory, loader always ready.
    lat = 1; gnt_pct = 100; rdy_pct = 100;
    run_load(32'h0000_1000, 20000);
    check("last_addr", last_gaddr, 32'h0000_4558);

    // Long latency, sporadic grants, 30% loader duty.
    lat = 10; gnt_pct = 70; rdy_pct = 30;
    run_load($urandom & 32'hFFFF_FFF8, 40000);

    // Reset in the middle of a load, then stale responses while idle.
    lat = 3; gnt_pct = 80; rdy_pct = 90;
    d0 = n_done;
    start_load($urandom & 32'hFFFF_FFF8);
    for (int i = 0; i < 10000 && exp_idx < 3000; i++) tick();
    check("reached_word_3000", exp_idx >= 3000, 1);
    rst = 1;
    #1;
    check_quiet("abort");
    tick(); tick();
    rst = 0; junk_en = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_quiet("stale_rvalid");
    end
    junk_en = 0;
    tick();
    check("no_done_after_abort", n_done, d0);

    // Fresh load after the abort.
    lat = 5; gnt_pct = 50; rdy_pct = 70;
    run_load($urandom & 32'hFFFF_FFF8, 40000);

`ifdef RDN_WSTREAM_CKSUM_EN
    ones_mode = 1; lat = 2; gnt_pct = 100; rdy_pct = 100;
    run_load(32'h0000_8000, 20000);
    check("cksum_all_ones", cksum, 16'h1AAF);
    tick(); tick();
    check("cksum_hold", cksum, 16'h1AAF);
    ones_mode = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rdn_weight_stream.md
Name: rdn_weight_stream

Overview:
Source side of the RDN weight-load interface. It fetches packed weight lines from memory, serializes them into 16-bit weight words, and presents them to rdn_weight_ld over its mem_ready/mem_data interface in A-layer, B-layer, C-layer order. Total payload is 15*401 + 15*16 + 36*16 = 6831 words.

Parameters:
ADDR_W, 32, byte address width of the memory port
LINE_W, 64, memory read-data width; 4 weight words per line
FIFO_LINES, 4, depth of the line buffer; also the maximum number of outstanding reads
NUM_WORDS, 6831, total weight words streamed per load

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
start  in  1  single-cycle pulse; begins a load
base_addr  in  ADDR_W  byte address of the first line, 8-byte aligned; sampled on start
mem_req  out  1  read request valid
mem_addr  out  ADDR_W  line byte address
mem_gnt  in  1  request accepted this cycle
mem_rvalid  in  1  read data valid; responses return in order
mem_rdata  in  LINE_W  read data
wt_valid  out  1  word available (drives loader mem_ready)
wt_data  out  16  weight word (drives loader mem_data)
wt_ready  in  1  loader consumes the word this cycle
busy  out  1  load in progress
done  out  1  one-cycle pulse after the last word is consumed

Behaviour:
- Reset value of every output is 0. The FSM returns to IDLE and all counters and the FIFO clear.
- FSM states:
  - IDLE: on start, latch base_addr, clear counters, go to RUN. start in any other state is ignored.
  - RUN: issue reads and stream words. When all 1708 line requests have been granted, go to DRAIN.
  - DRAIN: stream remaining words. When word 6831 is accepted, go to DONE.
  - DONE: assert done for 1 cycle, go to IDLE.
- busy = 1 in RUN, DRAIN and DONE.
- Request issue:
  - mem_req is asserted only while (outstanding + FIFO occupancy) < FIFO_LINES and lines_issued < 1708.
  - mem_addr = base + 8*lines_issued.
  - mem_req and mem_addr hold stable until mem_gnt.
  - Back-to-back grants are allowed, one per cycle.
- Response handling:
  - Each mem_rvalid pushes mem_rdata into the FIFO and decrements the outstanding count.
  - A push and a grant in the same cycle are both counted.
  - mem_rvalid while in IDLE is dropped; this covers stale responses after reset.
- Serializer:
  - The head line is emitted little-endian: bits[15:0] first, then [31:16], [47:32], [63:48].
  - wt_valid = 1 whenever the head line has an unsent word.
  - A word advances only on wt_valid & wt_ready. wt_data is stable while wt_valid & !wt_ready.
  - The line pops after its last word is accepted. The next line's word 0 may be presented the following cycle (throughput 1 word/cycle).
- Final line: 6831 mod 4 = 3, so only words 0..2 of line 1707 are emitted. Word 3 is discarded and that line pops after word 2.
- Latency: first wt_valid no earlier than 2 cycles after the first mem_rvalid.
- Full FIFO: no new request is issued; credit accounting guarantees no overflow. Empty FIFO: wt_valid = 0.
- Word counter is 13 bits and never wraps; it saturates at NUM_WORDS.
- Reset mid-operation aborts the load with no done pulse.

Optional Feature:
- Macro: RDN_WSTREAM_CKSUM_EN.
- When defined:
  - Adds output port cksum [15:0], the modulo-2^16 sum of all accepted words.
  - cksum clears on start and holds its value after done until the next start; reset value 0.
- When undefined: no port and no adder logic.

Decomposition:
- Shared package rdn_pkg:
  - NUM_A_NEURONS=15, NUM_B_NEURONS=15, NUM_C_NEURONS=36, A_INPUTS=400.
  - Derived constants NUM_WEIGHT_WORDS=6831 and NUM_WEIGHT_LINES=1708.
  - State enum type rdn_wstream_state_t.
- One sub-module, rdn_line_fifo: synchronous FIFO, LINE_W wide, FIFO_LINES deep, with count output. The top module holds the FSM, credit logic and serializer.

Test Plan:
- Zero-latency memory, wt_ready=1, base_addr=0x1000, mem_rdata = address pattern:
  - exactly 1708 grants, addresses 0x1000 to 0x4558;
  - 6831 words in order; done pulses once;
  - busy falls the cycle after done.
- Memory latency 10 cycles, FIFO_LINES=4: outstanding reads never exceed 4; no FIFO overflow.
- Random wt_ready at 30% duty: wt_data is stable across every stall; no word is lost or duplicated.
- Final line 0xDDDD_CCCC_BBBB_AAAA: last three words are 0xAAAA, 0xBBBB, 0xCCCC; 0xDDDD is never presented.
- rst asserted at word 3000, then mem_rvalid pulses in IDLE:
  - all outputs read 0 and no done pulse occurs;
  - a fresh start completes a full 6831-word load.
- With RDN_WSTREAM_CKSUM_EN, all words 0x0001: cksum = 6831 = 0x1AAF after done.
